// File: rtl/stream_min_finder.sv
// Streaming frame minimum finder: reports the minimum, the index of its first occurrence, the frame length and an overflow flag.
// Optional tie counting (out_count) is enabled by defining STREAM_MIN_TIE_COUNT_EN.
module stream_min_finder #(
  parameter int INPUT_SIZE = 4,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUT_SIZE-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUT_SIZE-1:0] out_min,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [IDX_WIDTH:0]    out_len,
  output logic                  out_ovf
`ifdef STREAM_MIN_TIE_COUNT_EN
  ,
  output logic [IDX_WIDTH:0]    out_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH:0] MAX_LEN = {1'b1, {IDX_WIDTH{1'b0}}};
  localparam logic [IDX_WIDTH:0] ONE     = (IDX_WIDTH+1)'(1);

  state_t                r_state;
  logic [INPUT_SIZE-1:0] r_min;
  logic [IDX_WIDTH-1:0]  r_idx;
  logic [IDX_WIDTH:0]    r_len;
  logic                  r_ovf;
  logic                  w_accept;
  logic                  w_full;
  logic                  w_less;
  logic                  w_equal;

  // Length never wraps: once the frame holds 2^IDX_WIDTH elements it saturates.
  function automatic logic [IDX_WIDTH:0] len_sat_inc(input logic [IDX_WIDTH:0] len);
    return (len == MAX_LEN) ? len : len + ONE;
  endfunction

  assign in_ready  = rst_n && (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_full    = (r_len == MAX_LEN);
  assign w_less    = (in_data < r_min);
  assign w_equal   = (in_data == r_min);

  assign out_min = r_min;
  assign out_idx = r_idx;
  assign out_len = r_len;
  assign out_ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_min   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_min   <= in_data;
            r_idx   <= '0;
            r_len   <= ONE;
            r_ovf   <= 1'b0;
            r_state <= in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            // Strict less-than keeps the earliest index on ties.
            if (w_full) begin
              r_ovf <= 1'b1;
            end else if (w_less) begin
              r_min <= in_data;
              r_idx <= r_len[IDX_WIDTH-1:0];
            end
            r_len <= len_sat_inc(r_len);
            if (in_last) r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef STREAM_MIN_TIE_COUNT_EN
  logic [IDX_WIDTH:0] r_count;

  assign out_count = r_count;

  // Overflowed beats are never compared, so they never touch the tie count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_count <= ONE;
      end else if (r_state == ACCUM && !w_full) begin
        if (w_less)       r_count <= ONE;
        else if (w_equal) r_count <= r_count + ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_min_finder.sv
// Directed self-checking bench for stream_min_finder (INPUT_SIZE=4, IDX_WIDTH=3).
module tb_stream_min_finder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_min;
  logic [2:0] out_idx;
  logic [3:0] out_len;
  logic       out_ovf;
`ifdef STREAM_MIN_TIE_COUNT_EN
  logic [3:0] out_count;
`endif

  int n_cmp;
  int n_err;

  stream_min_finder #(.INPUT_SIZE(4), .IDX_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_len   (out_len),
    .out_ovf   (out_ovf)
`ifdef STREAM_MIN_TIE_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat; inputs change #1 after the edge so they are stable at the next edge.
  task automatic beat(input int d, input bit last);
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int mn, input int idx, input int len,
                              input int ovf, input int cnt);
    check_eq({tag, ".valid"}, 32'(out_valid), 1);
    check_eq({tag, ".ready"}, 32'(in_ready), 0);
    check_eq({tag, ".min"},   32'(out_min), 32'(mn));
    check_eq({tag, ".idx"},   32'(out_idx), 32'(idx));
    check_eq({tag, ".len"},   32'(out_len), 32'(len));
    check_eq({tag, ".ovf"},   32'(out_ovf), 32'(ovf));
`ifdef STREAM_MIN_TIE_COUNT_EN
    check_eq({tag, ".count"}, 32'(out_count), 32'(cnt));
`else
    if (cnt < 0) $display("unused count %0d", cnt);
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, ".idle_valid"}, 32'(out_valid), 0);
    check_eq({tag, ".idle_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst.valid", 32'(out_valid), 0);
    check_eq("rst.ready", 32'(in_ready), 0);
    check_eq("rst.min",   32'(out_min), 0);
    check_eq("rst.idx",   32'(out_idx), 0);
    check_eq("rst.len",   32'(out_len), 0);
    check_eq("rst.ovf",   32'(out_ovf), 0);
`ifdef STREAM_MIN_TIE_COUNT_EN
    check_eq("rst.count", 32'(out_count), 0);
`endif
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst.ready", 32'(in_ready), 1);

    // Basic frame 7,3,9,3,1,1
    beat(7, 0); beat(3, 0); beat(9, 0); beat(3, 0); beat(1, 0); beat(1, 1);
    check_result("basic", 1, 4, 6, 0, 2);
    handshake("basic");

    // Single-beat frame
    beat(5, 1);
    check_result("single", 5, 0, 1, 0, 1);
    handshake("single");

    // Backpressure with offered beats that must not be accepted
    beat(4, 0); beat(2, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd0;
      in_last  = 1'b1;
      check_result("bp", 2, 1, 2, 0, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_end", 2, 1, 2, 0, 1);
    handshake("bp");

    // Overflow: nine 9s then 0 as the last beat
    for (int i = 0; i < 9; i++) beat(9, 0);
    beat(0, 1);
    check_result("ovf", 9, 0, 8, 1, 8);
    handshake("ovf");

    // Reset in the middle of a frame
    beat(6, 0); beat(1, 0); beat(8, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst.valid", 32'(out_valid), 0);
    check_eq("mid_rst.ready", 32'(in_ready), 0);
    check_eq("mid_rst.len",   32'(out_len), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(2, 0); beat(15, 1);
    check_result("after_rst", 2, 0, 2, 0, 1);
    handshake("after_rst");

    // Input bubbles
    beat(5, 0); gap(); gap(); beat(4, 0); gap(); beat(4, 1);
    check_result("bubble", 4, 1, 3, 0, 2);
    handshake("bubble");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
